// File: rtl/barrel_shifter_pkg.sv
// Shared mode encodings and the per-bit shift-step helper for the pipelined barrel shifter.
package barrel_shifter_pkg;

  localparam logic [1:0] MODE_ROR = 2'b00;
  localparam logic [1:0] MODE_ROL = 2'b01;
  localparam logic [1:0] MODE_SRL = 2'b10;
  localparam logic [1:0] MODE_SRA = 2'b11;

  // One output bit of a right shift by 2^k: a source bit that falls off the top
  // either wraps (rotate) or is replaced by the fill bit (logical/arithmetic).
  function automatic logic shift_bit(input logic en, input logic cur, input logic src,
                                     input logic in_range, input logic rot, input logic fill);
    logic res;
    if (!en)
      res = cur;
    else if (in_range || rot)
      res = src;
    else
      res = fill;
    return res;
  endfunction

endpackage

// File: rtl/barrel_shift_stage.sv
// One pipeline stage: conditional right shift by 2^STAGE_IDX on the way into a
// register, with valid/ready advance logic that lets bubbles collapse.
module barrel_shift_stage
  import barrel_shifter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int TAG_W     = 1,
  parameter int STAGE_IDX = 0,
  localparam int AMT_W    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic [AMT_W-1:0] i_amt,
  input  logic             i_rot,
  input  logic             i_fill,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [AMT_W-1:0] o_amt,
  output logic             o_rot,
  output logic             o_fill,
  output logic [TAG_W-1:0] o_tag
);

  localparam int DIST = 1 << STAGE_IDX;

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [AMT_W-1:0] r_amt;
  logic             r_rot;
  logic             r_fill;
  logic [TAG_W-1:0] r_tag;
  logic [WIDTH-1:0] w_shift;
  logic             w_adv;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    localparam int   SRC      = (i + DIST) % WIDTH;
    localparam logic IN_RANGE = ((i + DIST) < WIDTH);
    assign w_shift[i] = shift_bit(i_amt[STAGE_IDX], i_data[i], i_data[SRC],
                                  IN_RANGE, i_rot, i_fill);
  end

  // An empty stage always takes from upstream, even while downstream is stalled.
  assign w_adv   = !r_valid || i_ready;
  assign o_ready = w_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_amt   <= '0;
      r_rot   <= 1'b0;
      r_fill  <= 1'b0;
      r_tag   <= '0;
    end else if (w_adv) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= w_shift;
        r_amt  <= i_amt;
        r_rot  <= i_rot;
        r_fill <= i_fill;
        r_tag  <= i_tag;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_amt   = r_amt;
  assign o_rot   = r_rot;
  assign o_fill  = r_fill;
  assign o_tag   = r_tag;

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter (ROR/ROL/SRL/SRA), one stage per shift-amount bit,
// valid/ready on both sides with a tag carried alongside each result.
module barrel_shifter_pipe
  import barrel_shifter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int TAG_W  = 1,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  // Element 0 is the pre-processed input; element k+1 is the output of stage k.
  logic             w_vld  [AMT_W+1];
  logic             w_rdy  [AMT_W+1];
  logic [WIDTH-1:0] w_data [AMT_W+1];
  logic [AMT_W-1:0] w_amt  [AMT_W+1];
  logic             w_rot  [AMT_W+1];
  logic             w_fill [AMT_W+1];
  logic [TAG_W-1:0] w_tag  [AMT_W+1];

  // ROL by n is ROR by (WIDTH - n) mod WIDTH; the AMT_W-bit negate wraps naturally.
  assign w_vld[0]  = in_valid;
  assign w_data[0] = in_data;
  assign w_amt[0]  = (in_mode == MODE_ROL) ? -in_amt : in_amt;
  assign w_rot[0]  = (in_mode == MODE_ROR) || (in_mode == MODE_ROL);
  assign w_fill[0] = (in_mode == MODE_SRA) && in_data[WIDTH-1];
  assign w_tag[0]  = in_tag;

  assign w_rdy[AMT_W] = out_ready;
  assign in_ready     = w_rdy[0];

  for (genvar k = 0; k < AMT_W; k++) begin : g_stage
    barrel_shift_stage #(
      .WIDTH    (WIDTH),
      .TAG_W    (TAG_W),
      .STAGE_IDX(k)
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_valid(w_vld[k]),
      .o_ready(w_rdy[k]),
      .i_data (w_data[k]),
      .i_amt  (w_amt[k]),
      .i_rot  (w_rot[k]),
      .i_fill (w_fill[k]),
      .i_tag  (w_tag[k]),
      .o_valid(w_vld[k+1]),
      .i_ready(w_rdy[k+1]),
      .o_data (w_data[k+1]),
      .o_amt  (w_amt[k+1]),
      .o_rot  (w_rot[k+1]),
      .o_fill (w_fill[k+1]),
      .o_tag  (w_tag[k+1])
    );
  end

  assign out_valid = w_vld[AMT_W];
  assign out_data  = w_data[AMT_W];
  assign out_tag   = w_tag[AMT_W];
  assign out_zero  = ~|w_data[AMT_W];

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Scoreboard bench for barrel_shifter_pipe: an 8-bit and a 32-bit instance.
`timescale 1ns/1ps
module tb_barrel_shifter_pipe;

  localparam int W  = 8;
  localparam int AW = 3;
  localparam int TW = 4;
  localparam int W2 = 32;
  localparam int AW2 = 5;
  localparam logic [1:0] ROR = 2'b00, ROL = 2'b01, SRL = 2'b10, SRA = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b1;

  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [AW-1:0] in_amt = '0;
  logic [1:0]    in_mode = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic          out_zero;
  logic [TW-1:0] out_tag;

  logic           in_valid_b = 1'b0;
  logic           in_ready_b;
  logic [W2-1:0]  in_data_b = '0;
  logic [AW2-1:0] in_amt_b = '0;
  logic [1:0]     in_mode_b = '0;
  logic [TW-1:0]  in_tag_b = '0;
  logic           out_valid_b;
  logic           out_ready_b = 1'b1;
  logic [W2-1:0]  out_data_b;
  logic           out_zero_b;
  logic [TW-1:0]  out_tag_b;

  barrel_shifter_pipe #(.WIDTH(W), .TAG_W(TW)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_amt(in_amt),
    .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_zero(out_zero), .out_tag(out_tag)
  );

  barrel_shifter_pipe #(.WIDTH(W2), .TAG_W(TW)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b), .in_amt(in_amt_b),
    .in_mode(in_mode_b), .in_tag(in_tag_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .out_zero(out_zero_b), .out_tag(out_tag_b)
  );

  typedef struct {
    logic [31:0]   data;
    logic          zero;
    logic [TW-1:0] tag;
    int            acc;
    bit            chk_lat;
  } exp_t;

  exp_t q8[$];
  exp_t q32[$];
  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int or_mode = 1;  // 0: stall, 1: always ready, 2: random

  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(posedge clk);
    #2;
    case (or_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: rotates via a doubled word, shifts via native operators.
  function automatic logic [7:0] model8(input logic [7:0] d, input int n, input logic [1:0] m);
    logic [15:0] dd;
    logic signed [7:0] s;
    dd = {d, d};
    s  = d;
    case (m)
      ROR:     begin dd = dd >> n; return dd[7:0]; end
      ROL:     begin dd = dd << n; return dd[15:8]; end
      SRL:     return d >> n;
      default: return 8'(s >>> n);
    endcase
  endfunction

  task automatic send8(input logic [7:0] d, input int a, input logic [1:0] m,
                       input logic [3:0] t, input logic [7:0] e, output int waits);
    exp_t x;
    bit ok;
    in_data = d; in_amt = AW'(a); in_mode = m; in_tag = t; in_valid = 1'b1;
    waits = 0; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
      waits++;
      @(posedge clk); #1;
    end
    if (!ok) check("accept8_timeout", 32'(in_ready), 32'd1);
    else begin
      x.data = 32'(e); x.zero = (e == 8'h00); x.tag = t; x.acc = cyc; x.chk_lat = (or_mode == 1);
      q8.push_back(x);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send32(input logic [31:0] d, input int a, input logic [1:0] m,
                        input logic [3:0] t, input logic [31:0] e);
    exp_t x;
    bit ok;
    in_data_b = d; in_amt_b = AW2'(a); in_mode_b = m; in_tag_b = t; in_valid_b = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready_b) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) check("accept32_timeout", 32'(in_ready_b), 32'd1);
    else begin
      x.data = e; x.zero = (e == 32'h0); x.tag = t; x.acc = cyc; x.chk_lat = 1'b1;
      q32.push_back(x);
    end
    @(posedge clk); #1;
    in_valid_b = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (q8.size() != 0 || q32.size() != 0); i++) @(negedge clk);
    if (q8.size() != 0)  check("drain8_lost", 32'(q8.size()), 32'd0);
    if (q32.size() != 0) check("drain32_lost", 32'(q32.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  // 8-bit monitor: in-order pop, latency when never stalled, stall stability.
  logic [W-1:0]  prev_data;
  logic [TW-1:0] prev_tag;
  bit            prev_stall = 1'b0;
  always @(negedge clk) begin
    exp_t x;
    if (!rst_n) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(prev_data));
        check("stall_tag", 32'(out_tag), 32'(prev_tag));
      end
      if (out_valid && out_ready) begin
        if (q8.size() == 0) check("unexpected_out8", 32'(out_valid), 32'd0);
        else begin
          x = q8.pop_front();
          check("data8", 32'(out_data), x.data);
          check("zero8", 32'(out_zero), 32'(x.zero));
          check("tag8", 32'(out_tag), 32'(x.tag));
          if (x.chk_lat) check("latency8", 32'(cyc - x.acc), 32'd3);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_tag   = out_tag;
    end
  end

  always @(negedge clk) begin
    exp_t x;
    if (rst_n && out_valid_b) begin
      if (q32.size() == 0) check("unexpected_out32", 32'(out_valid_b), 32'd0);
      else begin
        x = q32.pop_front();
        check("data32", out_data_b, x.data);
        check("zero32", 32'(out_zero_b), 32'(x.zero));
        check("tag32", 32'(out_tag_b), 32'(x.tag));
        check("latency32", 32'(cyc - x.acc), 32'd5);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [7:0] d;
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_zero", 32'(out_zero), 32'd1);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_out_valid32", 32'(out_valid_b), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Directed mode vectors
    send8(8'h96, 3, ROR, 4'd1, 8'hD2, w);
    send8(8'h96, 3, ROL, 4'd2, 8'hB4, w);
    send8(8'h96, 3, SRL, 4'd3, 8'h12, w);
    send8(8'h96, 3, SRA, 4'd4, 8'hF2, w);
    send8(8'h5A, 0, ROR, 4'd5, 8'h5A, w);
    send8(8'h5A, 0, ROL, 4'd6, 8'h5A, w);
    send8(8'h5A, 0, SRL, 4'd7, 8'h5A, w);
    send8(8'h5A, 0, SRA, 4'd8, 8'h5A, w);
    send8(8'h80, 7, SRL, 4'd9, 8'h01, w);
    send8(8'h04, 3, SRL, 4'd10, 8'h00, w);
    send8(8'h81, 1, ROL, 4'd11, 8'h03, w);
    send8(8'h81, 7, SRA, 4'd12, 8'hFF, w);
    drain();

    // Back-to-back stream, tags 0..15
    for (int i = 0; i < 16; i++) begin
      d = 8'(i * 37 + 5);
      send8(d, i % 8, 2'(i % 4), 4'(i), model8(d, i % 8, 2'(i % 4)), w);
      check("stream_in_ready", 32'(w), 32'd0);
    end
    drain();

    // Bubble collapse under a stalled output
    or_mode = 0;
    send8(8'hA5, 1, ROR, 4'd1, 8'hD2, w);
    repeat (2) begin @(posedge clk); #1; end
    send8(8'h3C, 2, SRL, 4'd2, 8'h0F, w);
    check("bubble_ready_b", 32'(w), 32'd0);
    send8(8'hF0, 4, SRA, 4'd3, 8'hFF, w);
    check("bubble_ready_c", 32'(w), 32'd0);
    @(negedge clk);
    check("full_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;

    // Random backpressure with continuous input
    or_mode = 2;
    for (int i = 0; i < 24; i++) begin
      d = 8'(i * 53 + 17);
      send8(d, (i * 3) % 8, 2'(i % 4), 4'(i), model8(d, (i * 3) % 8, 2'(i % 4)), w);
    end
    or_mode = 1;
    drain();

    // Asynchronous reset mid-clock with three in flight
    or_mode = 0;
    send8(8'h11, 1, ROR, 4'd1, 8'h88, w);
    send8(8'h22, 1, ROR, 4'd2, 8'h11, w);
    send8(8'h33, 1, ROR, 4'd3, 8'h99, w);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_out_zero", 32'(out_zero), 32'd1);
    q8.delete();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    or_mode = 1;
    @(negedge clk);
    check("in_ready_after_midrst", 32'(in_ready), 32'd1);
    repeat (6) @(posedge clk);
    #1;
    send8(8'h96, 3, ROR, 4'd7, 8'hD2, w);
    drain();

    // 32-bit instance
    send32(32'h8000_0001, 31, SRA, 4'd5, 32'hFFFF_FFFF);
    send32(32'h8000_0001, 1, ROL, 4'd6, 32'h0000_0003);
    send32(32'h0000_0010, 5, SRL, 4'd7, 32'h0000_0000);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/barrel_shifter_pipe.md
# barrel_shifter_pipe

Parametrised, pipelined barrel shifter that generalises the fixed 8-bit rotate-right shifter to any power-of-two width. It supports four shift modes with a per-transaction shift amount and mode, and carries a sideband tag. It sits between producer and consumer datapath blocks behind a valid/ready handshake and sustains one result per cycle. It has one register stage per shift-amount bit, and bubbles collapse under backpressure.

## Interface
- WIDTH, 8, data width; power of two, ≥ 2
- TAG_W, 1, sideband tag width, passed through unmodified
- AMT_W (localparam), $clog2(WIDTH), shift-amount width; also the number of pipeline stages
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input transaction present
- in_ready  out  1  block accepts input this cycle
- in_data  in  WIDTH  operand
- in_amt  in  AMT_W  shift amount, 0..WIDTH-1
- in_mode  in  2  00 ROR, 01 ROL, 10 SRL (logical right), 11 SRA (arithmetic right)
- in_tag  in  TAG_W  user sideband
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  shifted result
- out_zero  out  1  out_data == 0
- out_tag  out  TAG_W  tag of this result

## Operation
- Transfer occurs on a cycle with valid && ready, on either side.
- Input pre-processing is combinational and registered into stage 0 with the operand:
  - ROL by n is executed as ROR by (WIDTH − n) mod WIDTH, computed in AMT_W-bit arithmetic with natural wrap. ROL by 0 stays 0.
  - Fill bit is 0 for SRL, in_data[WIDTH-1] for SRA, and unused for the rotates.
- Stage k (k = 0..AMT_W-1) shifts right by 2^k when effective amount bit k is set, otherwise passes the data through:
  - Rotate modes wrap vacated high bits from the low end.
  - SRL/SRA modes fill vacated high bits with the fill bit.
- Each stage register holds: valid, data, effective amount, is_rotate flag, fill bit, tag.
- out_zero is computed combinationally from the final stage's data.
- amt = 0 passes data through unchanged in all modes.
- Tag and ordering are preserved strictly FIFO. No reordering and no drops.

## Timing
- Latency is exactly AMT_W cycles from input transfer to out_valid, with no stall (3 for WIDTH=8). Throughput is 1/cycle.
- Stage k advances when stage k is empty or stage k+1 advances. The last stage advances when out_ready is high or it is empty.
- in_ready = stage 0 empty OR stage 0 advancing. in_ready is combinational from out_ready through the advance chain.
- Under stall, all full stages hold data, tag and control stable. out_data/out_tag must not change while out_valid && !out_ready.
- Bubbles collapse: an empty stage accepts from upstream even when downstream is stalled.
- Simultaneous in transfer and out transfer in the same cycle is legal and loses nothing.
- Reset, asynchronous assertion at any time, including mid-stream:
  - All stage valids clear to 0; out_valid = 0; in-flight data is discarded.
  - out_data, out_tag = 0; out_zero = 1.
  - in_ready = 1 from the first cycle after deassertion.
- Data registers may be reset for determinism; functional correctness depends only on the valids.

## Structure
- Package barrel_shifter_pkg:
  - mode localparams MODE_ROR=2'b00, MODE_ROL=2'b01, MODE_SRL=2'b10, MODE_SRA=2'b11;
  - a function for stage-amount shifting by 2^k with a fill/rotate select.
- Sub-module barrel_shift_stage (parameters WIDTH, TAG_W, STAGE_IDX):
  - contains one registered shift step plus the valid/advance logic;
  - the top generates AMT_W instances in a chain and adds the input pre-processing and out_zero.

## Test plan
- WIDTH=8, in_data=0x96, amt=3 in each mode, out_ready=1 → ROR 0xD2, ROL 0xB4, SRL 0x12, SRA 0xF2; each appears exactly 3 cycles after acceptance.
- amt=0, all modes, data=0x5A → 0x5A; SRL by 7 of 0x80 → 0x01 with out_zero=0; SRL by 3 of 0x04 → 0x00 with out_zero=1.
- Back-to-back stream of 16 transfers, tags 0..15, out_ready=1 → 16 results in order, one per cycle, tags match, in_ready held high.
- Random out_ready toggling with continuous in_valid, checked against a reference model:
  - no loss or duplication;
  - outputs stable during stall;
  - bubble collapse: after 2 idle input cycles and a stall, in_ready stays 1 until all 3 stages are full.
- rst_n asserted asynchronously mid-clock with 3 transactions in flight → out_valid drops immediately, nothing emerges after release, and the next input yields the correct result after 3 cycles.
- WIDTH=32, TAG_W=4: SRA of 0x8000_0001 by 31 → 0xFFFF_FFFF; ROL by 1 → 0x0000_0003; latency 5.
